// File: rtl/pool_2x2_stream.sv
// Streaming 2x2/stride-2 max-pool over three channels with a row buffer.
// Define POOL_SIGNED_EN for signed compares; the default build compares unsigned.
module pool_2x2_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [DW-1:0] in_D1,
    input  logic [DW-1:0] in_D2,
    input  logic [DW-1:0] in_D3,
    output logic          out_vld,
    output logic [1:0]    r_cnt,
    output logic [1:0]    c_cnt,
    output logic [DW-1:0] ans_2x2_D1,
    output logic [DW-1:0] ans_2x2_D2,
    output logic [DW-1:0] ans_2x2_D3,
    output logic          frame_done
);

    localparam int HW = IMG_W / 2;
    localparam logic [2:0] LAST = 3'(IMG_W - 1);

    logic [2:0]    col_q, col_d;
    logic [2:0]    row_q, row_d;
    logic [DW-1:0] hold_q [3];
    logic [DW-1:0] hold_d [3];
    logic [DW-1:0] rb_q   [3][HW];
    logic [DW-1:0] rb_d   [3][HW];
    logic [DW-1:0] ans_q  [3];
    logic [DW-1:0] ans_d  [3];
    logic [1:0]    r_cnt_q, r_cnt_d;
    logic [1:0]    c_cnt_q, c_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic          frame_done_q, frame_done_d;

    logic [DW-1:0] in_d [3];
    logic [DW-1:0] hmax [3];
    logic [1:0]    idx;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
`ifdef POOL_SIGNED_EN
        max2 = ($signed(a) > $signed(b)) ? a : b;
`else
        max2 = (a > b) ? a : b;
`endif
    endfunction

    assign in_d[0] = in_D1;
    assign in_d[1] = in_D2;
    assign in_d[2] = in_D3;
    assign idx     = col_q[2:1];

    always_comb begin
        for (int k = 0; k < 3; k++) hmax[k] = max2(hold_q[k], in_d[k]);
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        rb_d         = rb_q;
        ans_d        = ans_q;
        r_cnt_d      = r_cnt_q;
        c_cnt_d      = c_cnt_q;
        out_vld_d    = 1'b0;
        frame_done_d = 1'b0;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (in_vld) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? 3'd0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
            if (!col_q[0]) begin
                hold_d = in_d;
            end else if (!row_q[0]) begin
                for (int k = 0; k < 3; k++) rb_d[k][idx] = hmax[k];
            end else begin
                // Bottom-right beat: fold the buffered top-row max in.
                for (int k = 0; k < 3; k++)
                    ans_d[k] = max2(rb_q[k][idx], hmax[k]);
                r_cnt_d      = row_q[2:1];
                c_cnt_d      = idx;
                out_vld_d    = 1'b1;
                frame_done_d = (row_q == LAST) && (col_q == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            r_cnt_q      <= '0;
            c_cnt_q      <= '0;
            out_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                hold_q[k] <= '0;
                ans_q[k]  <= '0;
                for (int j = 0; j < HW; j++) rb_q[k][j] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            rb_q         <= rb_d;
            ans_q        <= ans_d;
            r_cnt_q      <= r_cnt_d;
            c_cnt_q      <= c_cnt_d;
            out_vld_q    <= out_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign frame_done = frame_done_q;
    assign r_cnt      = r_cnt_q;
    assign c_cnt      = c_cnt_q;
    assign ans_2x2_D1 = ans_q[0];
    assign ans_2x2_D2 = ans_q[1];
    assign ans_2x2_D3 = ans_q[2];

endmodule

// File: tb/tb_pool_2x2_stream.sv
// Randomised/directed bench for pool_2x2_stream against a frame-array model.
// The model honours POOL_SIGNED_EN the same way the design build does.
module tb_pool_2x2_stream;

    localparam int W = 6;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_vld;
    logic [7:0] in_D1, in_D2, in_D3;
    logic       out_vld, frame_done;
    logic [1:0] r_cnt, c_cnt;
    logic [7:0] ans_2x2_D1, ans_2x2_D2, ans_2x2_D3;

    always #5 clk = ~clk;

    pool_2x2_stream #(.DW(8), .IMG_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld),
        .in_D1(in_D1), .in_D2(in_D2), .in_D3(in_D3),
        .out_vld(out_vld), .r_cnt(r_cnt), .c_cnt(c_cnt),
        .ans_2x2_D1(ans_2x2_D1), .ans_2x2_D2(ans_2x2_D2),
        .ans_2x2_D3(ans_2x2_D3), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0] d1, d2, d3;
        logic [1:0] r, c;
        logic       fd;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         nvld  = 0;
    int         nfd   = 0;
    int         br    = 0;
    int         bc    = 0;
    logic [7:0] pix [3][W][W];
    logic [7:0] got [3][3][3];
    exp_t       q[$];

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
`ifdef POOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    function automatic logic [7:0] wmax(input int ch, input int r, input int c);
        return mx(mx(pix[ch][r-1][c-1], pix[ch][r-1][c]),
                  mx(pix[ch][r][c-1], pix[ch][r][c]));
    endfunction

    function automatic logic [7:0] pv(input int mode, input int ch,
                                      input int r, input int c);
        int ramp;
        ramp = r * 6 + c;
        case (mode)
            0: return 8'(ramp);
            1: return (r % 2 == 0 && c % 2 == 0) ? 8'd200 : 8'd10;
            2: return (ch == 0) ? 8'd5 : (ch == 1) ? 8'(ramp) : 8'(255 - ramp);
            3: return 8'($urandom);
            default: begin
                if (r == 0 && c == 0) return 8'h80;
                if (r == 0 && c == 1) return 8'h7F;
                if (r == 1 && c == 0) return 8'h01;
                return 8'h00;
            end
        endcase
    endfunction

    task automatic beat(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int gap);
        exp_t e;
        pix[0][br][bc] = a;
        pix[1][br][bc] = b;
        pix[2][br][bc] = c;
        if (br % 2 == 1 && bc % 2 == 1) begin
            e.d1 = wmax(0, br, bc);
            e.d2 = wmax(1, br, bc);
            e.d3 = wmax(2, br, bc);
            e.r  = 2'(br / 2);
            e.c  = 2'(bc / 2);
            e.fd = (br == W - 1) && (bc == W - 1);
            q.push_back(e);
        end
        in_vld = 1'b1;
        in_D1  = a;
        in_D2  = b;
        in_D3  = c;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_D1  = 8'($urandom);
        bc++;
        if (bc == W) begin
            bc = 0;
            br = (br == W - 1) ? 0 : br + 1;
        end
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int mode, input int gmax);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                beat(pv(mode, 0, r, c), pv(mode, 1, r, c), pv(mode, 2, r, c),
                     $urandom_range(gmax, 0));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_vld) begin
                nvld++;
                if (q.size() == 0) begin
                    chk("unexpected_vld", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ans_d1", ans_2x2_D1, e.d1);
                    chk("ans_d2", ans_2x2_D2, e.d2);
                    chk("ans_d3", ans_2x2_D3, e.d3);
                    chk("r_cnt", r_cnt, e.r);
                    chk("c_cnt", c_cnt, e.c);
                    chk("frame_done", frame_done, e.fd);
                end
                got[0][r_cnt][c_cnt] = ans_2x2_D1;
                got[1][r_cnt][c_cnt] = ans_2x2_D2;
                got[2][r_cnt][c_cnt] = ans_2x2_D3;
            end else begin
                chk("fd_without_vld", frame_done, 0);
            end
            if (frame_done) nfd++;
        end
    end

    initial begin
        int n0, f0;
        rst_n = 1'b0;
        clr = 1'b0;
        in_vld = 1'b0;
        in_D1 = '0;
        in_D2 = '0;
        in_D3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", out_vld, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_rc", {r_cnt, c_cnt}, 0);
        chk("rst_ans", {ans_2x2_D1, ans_2x2_D2, ans_2x2_D3}, 0);
        rst_n = 1'b1;
        settle();

        n0 = nvld; f0 = nfd;
        frame(0, 0);
        settle();
        chk("ramp_pulses", nvld - n0, 9);
        chk("ramp_fd", nfd - f0, 1);
        chk("ramp_00", got[0][0][0], 7);
        chk("ramp_01", got[0][0][1], 9);
        chk("ramp_02", got[1][0][2], 11);
        chk("ramp_10", got[2][1][0], 19);
        chk("ramp_22", got[0][2][2], 35);

        frame(1, 0);
        settle();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    chk("topleft", got[k][r][c], 200);

        frame(2, 1);
        settle();
        chk("chan_d1", got[0][1][1], 5);
        chk("chan_d2", got[1][2][2], 35);
        chk("chan_d3_00", got[2][0][0], 255);
        chk("chan_d3_22", got[2][2][2], 227);

        n0 = nvld; f0 = nfd;
        frame(0, 3);
        frame(0, 0);
        settle();
        chk("gap_pulses", nvld - n0, 18);
        chk("gap_fd", nfd - f0, 2);

        for (int i = 0; i < 20; i++)
            beat(pv(0, 0, i / W, i % W), pv(0, 1, i / W, i % W),
                 pv(0, 2, i / W, i % W), 0);
        clr = 1'b1;
        in_vld = 1'b1;
        in_D1 = 8'hFF;
        in_D2 = 8'hFF;
        in_D3 = 8'hFF;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_vld = 1'b0;
        br = 0;
        bc = 0;
        chk("clr_vld", out_vld, 0);
        n0 = nvld;
        frame(0, 0);
        settle();
        chk("clr_pulses", nvld - n0, 9);

        frame(3, 2);
        frame(3, 0);
        settle();

        frame(4, 0);
        settle();
`ifdef POOL_SIGNED_EN
        chk("sign_max", got[0][0][0], 8'h7F);
`else
        chk("sign_max", got[0][0][0], 8'h80);
`endif

        for (int i = 0; i < 9; i++)
            beat(pv(1, 0, i / W, i % W), pv(1, 1, i / W, i % W),
                 pv(1, 2, i / W, i % W), 0);
        settle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_fd", frame_done, 0);
        chk("mid_rst_rc", {r_cnt, c_cnt}, 0);
        chk("mid_rst_ans", {ans_2x2_D1, ans_2x2_D2, ans_2x2_D3}, 0);
        q.delete();
        br = 0;
        bc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = nvld;
        frame(0, 0);
        settle();
        chk("post_rst_pulses", nvld - n0, 9);
        chk("post_rst_00", got[0][0][0], 7);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_2x2_stream.md
# pool_2x2_stream

Streaming 2x2/stride-2 max-pool stage for the three-channel feature path. Accepts a raster-ordered IMG_W x IMG_W map, three 8-bit channels per beat, and emits one pooled value per channel per window together with its output row/column index. It sits directly upstream of the pooled-map storage stage, which captures `ans_2x2_D1..D3` at `r_cnt`/`c_cnt` on `out_vld`.

## Interface
- `DW`, default 8: pixel width per channel.
- `IMG_W`, default 6: input map height and width. Must be even and no larger than 8. Output map is IMG_W/2 square.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous frame restart. Clears counters, pending state and `out_vld`.
- `in_vld`  in  1  input beat valid. There is no backpressure; the block is always ready.
- `in_D1`, `in_D2`, `in_D3`  in  DW  channel pixels for the current beat.
- `out_vld`  out  1  one-cycle pulse per pooled window.
- `r_cnt`, `c_cnt`  out  2  output row/column index of the window, 0..IMG_W/2-1.
- `ans_2x2_D1`, `ans_2x2_D2`, `ans_2x2_D3`  out  DW  window maximum per channel.
- `frame_done`  out  1  pulse coincident with the last window's `out_vld`.

## Operation
- Input counters `col`, `row` run 0..IMG_W-1 in raster order.
  - They advance only on `in_vld`.
  - `col` wraps to 0 and increments `row`.
  - After (`row`=IMG_W-1, `col`=IMG_W-1), both wrap to 0, and the next frame starts with no idle cycle.
- Beat at even `col`: latch each channel into `hold_Dk`.
- Beat at odd `col`: `hmax_k = max(hold_Dk, in_Dk)`. This value is combinational and is not stored.
- Even `row`, odd `col`: write `hmax_k` into row buffer `rb_k[col>>1]`. Each channel has IMG_W/2 entries of DW bits.
- Odd `row`, odd `col`: register the outputs.
  - `ans_2x2_Dk <= max(rb_k[col>>1], hmax_k)`.
  - `r_cnt <= row>>1`, `c_cnt <= col>>1`.
  - `out_vld <= 1`.
- `frame_done <= 1` on the same update when `row`=IMG_W-1 and `col`=IMG_W-1.
- Comparisons are unsigned unless the Configuration macro is defined. Equal values yield that value; no tie-break is visible.
- `clr` has priority over `in_vld` in the same cycle; that beat is dropped. `clr` zeroes `col`, `row`, `out_vld` and `frame_done`. `hold`, `rb`, `ans` and the indices keep their values, and `rb` is overwritten before its next use.
- Reset mid-frame: all state goes to reset values and the next beat is treated as pixel (0,0).

## Timing
- Reset values: `out_vld`=0, `frame_done`=0, `r_cnt`=0, `c_cnt`=0, all `ans_2x2_Dk`=0. `hold`, `rb` and counters are also 0.
- Latency: `out_vld` is high in the cycle after the clock edge that samples the window's bottom-right beat, i.e. one cycle.
- `out_vld` and `frame_done` are single-cycle pulses. They drop the next cycle regardless of `in_vld`.
- `ans`, `r_cnt` and `c_cnt` hold their last values while `out_vld`=0.
- Gaps in `in_vld` of any length are allowed anywhere. Results are identical to back-to-back input.
- Throughput: one pixel per cycle, so at most one window every 2 cycles.
- Per frame: exactly (IMG_W/2)^2 `out_vld` pulses, 9 at the default. Order is `r_cnt` major, `c_cnt` minor.

## Configuration
- `POOL_SIGNED_EN`
  - Defined: all max comparisons treat pixels as two's-complement signed DW-bit values.
  - Undefined (default): unsigned comparison, for post-ReLU data.
- Port list and timing are identical in both builds.

## Test plan
- Ramp: all channels = `row*6+col`, back-to-back. Expect 9 pulses:
  - (0,0)=7, (0,1)=9, (0,2)=11, (1,0)=19, (2,2)=35.
  - `frame_done` only with (2,2).
- Top-left max: each window's top-left pixel = 200, others = 10. Expect all 27 outputs = 200, which exercises the row-buffer path.
- Channel independence: D1 = 5, D2 = ramp, D3 = 255-ramp. Expect:
  - D1 = 5 everywhere.
  - D2 as in the ramp test.
  - D3 = 255-(12r+2c); (0,0)=255, (2,2)=227.
- Gapped input: ramp frame with random 0-3 idle cycles between beats, then a second frame immediately. Expect the same values, 18 `out_vld` pulses and 2 `frame_done` pulses.
- `clr` mid-frame after 20 beats, with `clr` and `in_vld` high together, then a full ramp frame. Expect no output from the partial frame and 9 outputs matching the ramp test.
- Sign: a window of {0x80, 0x7F, 0x01, 0x00}. Expect 0x80 without `POOL_SIGNED_EN` and 0x7F with it. Also assert `rst_n` low mid-frame and check that all outputs are 0 and the next beat is (0,0).
